// File: rtl/adc_capture_wr_ctrl_if.sv
// Capture-memory write port between the ADC capture controller and memory.
// Define ADC_CAP_PARITY_EN to widen write data by one even-parity bit.
interface adc_capture_wr_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
`ifdef ADC_CAP_PARITY_EN
    localparam int WD_W = DATA_W + 1;
`else
    localparam int WD_W = DATA_W;
`endif

    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WD_W-1:0]   mem_wdata;

    modport master (
        output mem_wen,
        output mem_waddr,
        output mem_wdata
    );

    modport slave (
        input mem_wen,
        input mem_waddr,
        input mem_wdata
    );
endinterface

// File: rtl/adc_capture_wr_ctrl.sv
// ADC capture write controller: fills one buffer from address 0, then DONE.
// Optional macro ADC_CAP_PARITY_EN appends an even-parity bit to write data.
module adc_capture_wr_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 14,
    parameter int DECIM_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_start,
    input  logic                capture_again,
    input  logic                self_test_mode,
    input  logic [DECIM_W-1:0]  decim,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    input  logic                rd_busy,
    adc_capture_wr_ctrl_if.master wr,
    output logic                capture_busy,
    output logic                capture_done,
    output logic                pend_again
);
`ifdef ADC_CAP_PARITY_EN
    localparam int WD_W = DATA_W + 1;
`else
    localparam int WD_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ARM_WAIT,
        CAPTURE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic                enter_cap;
    logic                accept;
    logic                last;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DECIM_W-1:0]  decim_cnt_q;
    logic [DECIM_W-1:0]  decim_q;
    logic [DATA_W-1:0]   ramp_q;
    logic [DATA_W-1:0]   sel;
    logic [WD_W-1:0]     wd;
    logic                wen_q;
    logic [ADDR_W-1:0]   wa_q;
    logic [WD_W-1:0]     wd_q;

    assign accept = (state_q == CAPTURE) && adc_valid
                    && (decim_cnt_q == '0);
    assign last   = accept && (&waddr_q);
    assign sel    = self_test_mode ? ramp_q : adc_data;

`ifdef ADC_CAP_PARITY_EN
    assign wd = {^sel, sel};
`else
    assign wd = sel;
`endif

    // Next-state logic; DONE requests queue behind rd_busy via ARM_WAIT.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        enter_cap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture_start) begin
                    state_d   = CAPTURE;
                    enter_cap = 1'b1;
                end
            end
            ARM_WAIT: begin
                if (!rd_busy) begin
                    state_d   = CAPTURE;
                    enter_cap = 1'b1;
                    pend_d    = 1'b0;
                end
            end
            CAPTURE: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (capture_start || capture_again) begin
                    if (rd_busy) begin
                        state_d = ARM_WAIT;
                        pend_d  = capture_again;
                    end else begin
                        state_d   = CAPTURE;
                        enter_cap = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and queued-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Address, decimation and ramp counters; cleared on every capture entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q     <= '0;
            decim_cnt_q <= '0;
            decim_q     <= '0;
            ramp_q      <= '0;
        end else if (enter_cap) begin
            waddr_q     <= '0;
            decim_cnt_q <= '0;
            decim_q     <= decim;
            ramp_q      <= '0;
        end else if (state_q == CAPTURE && adc_valid) begin
            if (decim_cnt_q == decim_q) begin
                decim_cnt_q <= '0;
            end else begin
                decim_cnt_q <= decim_cnt_q + 1'b1;
            end
            if (accept) begin
                waddr_q <= waddr_q + 1'b1;
                ramp_q  <= ramp_q + 1'b1;
            end
        end
    end

    // One-cycle write stage: accepted sample appears on the bus next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                wa_q <= waddr_q;
                wd_q <= wd;
            end
        end
    end

    assign wr.mem_wen    = wen_q;
    assign wr.mem_waddr  = wa_q;
    assign wr.mem_wdata  = wd_q;
    assign capture_busy  = (state_q == ARM_WAIT) || (state_q == CAPTURE);
    assign capture_done  = (state_q == DONE);
    assign pend_again    = pend_q;
endmodule

// File: tb/tb_adc_capture_wr_ctrl.sv
// Directed bench for adc_capture_wr_ctrl with a 16-entry buffer.
// Honours ADC_CAP_PARITY_EN when building expected write data.
module tb_adc_capture_wr_ctrl;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int DECIM_W = 4;
`ifdef ADC_CAP_PARITY_EN
    localparam int WD_W = DATA_W + 1;
`else
    localparam int WD_W = DATA_W;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               capture_start;
    logic               capture_again;
    logic               self_test_mode;
    logic [DECIM_W-1:0] decim;
    logic [DATA_W-1:0]  adc_data;
    logic               adc_valid;
    logic               rd_busy;
    logic               capture_busy;
    logic               capture_done;
    logic               pend_again;

    int n_assert = 0;
    int n_fail   = 0;

    adc_capture_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

    adc_capture_wr_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DECIM_W(DECIM_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .capture_start (capture_start),
        .capture_again (capture_again),
        .self_test_mode(self_test_mode),
        .decim         (decim),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .rd_busy       (rd_busy),
        .wr            (wr_if),
        .capture_busy  (capture_busy),
        .capture_done  (capture_done),
        .pend_again    (pend_again)
    );

    always #5 clk = ~clk;

    function automatic logic [WD_W-1:0] wd(input logic [15:0] d);
`ifdef ADC_CAP_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int a,
                          input logic [15:0] d);
        chk({tag, "/wen"}, 32'(wr_if.mem_wen), 32'd1);
        chk({tag, "/addr"}, 32'(wr_if.mem_waddr), 32'(a));
        chk({tag, "/data"}, 32'(wr_if.mem_wdata), 32'(wd(d)));
    endtask

    task automatic chk_nowr(input string tag);
        chk({tag, "/wen"}, 32'(wr_if.mem_wen), 32'd0);
    endtask

    task automatic sample(input logic [15:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        step();
    endtask

    initial begin
        rst            = 1'b1;
        capture_start  = 1'b0;
        capture_again  = 1'b0;
        self_test_mode = 1'b0;
        decim          = '0;
        adc_data       = '0;
        adc_valid      = 1'b0;
        rd_busy        = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst/wen", 32'(wr_if.mem_wen), 32'd0);
        chk("rst/busy", 32'(capture_busy), 32'd0);
        chk("rst/done", 32'(capture_done), 32'd0);
        chk("rst/pend", 32'(pend_again), 32'd0);

        // Basic capture, every valid sample kept.
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        chk("basic/busy", 32'(capture_busy), 32'd1);
        chk_nowr("basic/entry");
        for (int n = 0; n < 16; n++) begin
            sample(16'(16'h100 + n));
            chk_wr("basic", n, 16'(16'h100 + n));
            if (n < 15) chk("basic/notdone", 32'(capture_done), 32'd0);
        end
        chk("basic/done", 32'(capture_done), 32'd1);
        chk("basic/idle", 32'(capture_busy), 32'd0);
        sample(16'h110);
        chk_nowr("basic/extra");
        chk("basic/hold", 32'(capture_done), 32'd1);

        // Decimation by 3; decim changed after latch.
        decim         = 4'd2;
        capture_again = 1'b1;
        adc_valid     = 1'b0;
        step();
        capture_again = 1'b0;
        decim         = 4'd0;
        chk("decim/busy", 32'(capture_busy), 32'd1);
        chk("decim/done0", 32'(capture_done), 32'd0);
        for (int i = 0; i < 48; i++) begin
            sample(16'(16'h200 + i));
            if (i % 3 == 0) chk_wr("decim", i / 3, 16'(16'h200 + i));
            else chk_nowr("decim/skip");
        end
        chk("decim/done", 32'(capture_done), 32'd1);

        // Self-test ramp.
        self_test_mode = 1'b1;
        capture_start  = 1'b1;
        adc_valid      = 1'b0;
        step();
        capture_start = 1'b0;
        for (int n = 0; n < 16; n++) begin
            sample(16'hFFFF);
            chk_wr("ramp", n, 16'(n));
        end
        chk("ramp/done", 32'(capture_done), 32'd1);

        // Hold-off behind rd_busy for 20 cycles.
        self_test_mode = 1'b0;
        rd_busy        = 1'b1;
        capture_again  = 1'b1;
        adc_valid      = 1'b1;
        step();
        capture_again = 1'b0;
        chk("hold/pend", 32'(pend_again), 32'd1);
        chk("hold/busy", 32'(capture_busy), 32'd1);
        chk("hold/done", 32'(capture_done), 32'd0);
        chk_nowr("hold/first");
        for (int c = 1; c < 20; c++) begin
            sample(16'h5555);
            chk_nowr("hold/wait");
            chk("hold/pendw", 32'(pend_again), 32'd1);
        end
        rd_busy = 1'b0;
        sample(16'h5555);
        chk("hold/pendclr", 32'(pend_again), 32'd0);
        chk("hold/busy2", 32'(capture_busy), 32'd1);
        chk_nowr("hold/arm");
        for (int n = 0; n < 16; n++) begin
            sample(16'(16'h300 + n));
            chk_wr("hold", n, 16'(16'h300 + n));
        end
        chk("hold/fin", 32'(capture_done), 32'd1);

        // Ramp restarts on capture_again; reset after 7 writes.
        self_test_mode = 1'b1;
        capture_again  = 1'b1;
        adc_valid      = 1'b0;
        step();
        capture_again = 1'b0;
        for (int n = 0; n < 7; n++) begin
            sample(16'h0000);
            chk_wr("restart", n, 16'(n));
        end
        rst       = 1'b1;
        adc_valid = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst/wen", 32'(wr_if.mem_wen), 32'd0);
        chk("mrst/addr", 32'(wr_if.mem_waddr), 32'd0);
        chk("mrst/data", 32'(wr_if.mem_wdata), 32'd0);
        chk("mrst/busy", 32'(capture_busy), 32'd0);
        chk("mrst/done", 32'(capture_done), 32'd0);
        chk("mrst/pend", 32'(pend_again), 32'd0);

        // capture_again ignored in IDLE.
        capture_again = 1'b1;
        sample(16'h0000);
        capture_again = 1'b0;
        chk("idle/again", 32'(capture_busy), 32'd0);
        sample(16'h0000);
        chk_nowr("idle/nowr");

        // Fresh capture from addr 0; start ignored mid-capture.
        self_test_mode = 1'b0;
        capture_start  = 1'b1;
        adc_valid      = 1'b0;
        step();
        capture_start = 1'b0;
        chk("again/busy", 32'(capture_busy), 32'd1);
        sample(16'h400);
        chk_wr("again", 0, 16'h400);
        sample(16'h401);
        chk_wr("again", 1, 16'h401);
        capture_start = 1'b1;
        sample(16'h402);
        capture_start = 1'b0;
        chk_wr("again/ign", 2, 16'h402);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_capture_wr_ctrl.md
Name: adc_capture_wr_ctrl

Overview:
- Upstream neighbour of the package controller.
- Accepts the ADC sample stream, optionally decimates it or substitutes a self-test ramp, and writes exactly one buffer's worth of samples into capture memory starting at address 0.
- Signals capture_done to the package controller. Holds off a re-capture while the package controller is still reading.

Parameters:
- DATA_W, 16: ADC sample width.
- ADDR_W, 14: capture memory address width. Buffer depth = 2**ADDR_W.
- DECIM_W, 4: width of the decimation control.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- capture_start  in  1  one-cycle pulse from the regfile; begins a capture.
- capture_again  in  1  one-cycle pulse from the regfile; re-captures after done.
- self_test_mode  in  1  1 = write an internal ramp instead of adc_data.
- decim  in  DECIM_W  keep one of every decim+1 valid samples. Latched at capture start.
- adc_data  in  DATA_W  ADC sample.
- adc_valid  in  1  adc_data qualifier.
- rd_busy  in  1  package controller is reading memory.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W (DATA_W+1 with macro)  memory write data.
- capture_busy  out  1  high in ARM_WAIT or CAPTURE.
- capture_done  out  1  level, high in DONE.
- pend_again  out  1  a capture_again is queued behind rd_busy.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs 0. Internal counters 0. Reset mid-capture abandons the capture with no further writes.
- States: IDLE, ARM_WAIT, CAPTURE, DONE.
- IDLE:
  - capture_start -> CAPTURE next cycle.
  - capture_again is ignored.
- DONE:
  - capture_start or capture_again with rd_busy=0 -> CAPTURE.
  - capture_again with rd_busy=1 -> ARM_WAIT, pend_again=1.
  - capture_start while rd_busy=1 also goes to ARM_WAIT.
- ARM_WAIT: first cycle with rd_busy=0 -> CAPTURE. pend_again clears on that transition.
- CAPTURE: capture_start and capture_again are ignored (no restart, no queueing).
- On every entry to CAPTURE:
  - waddr=0, decim_cnt=0, ramp=0.
  - decim latched.
  - capture_done=0 in the same cycle the transition registers.
- Sample acceptance in CAPTURE: a sample is accepted when adc_valid=1 and decim_cnt==0.
  - decim_cnt increments on every adc_valid.
  - decim_cnt wraps to 0 after reaching latched decim.
  - decim=0 accepts every valid sample.
- Write timing: accepted at edge n -> mem_wen=1 during cycle n+1, with mem_waddr=waddr and mem_wdata = (self_test_mode ? ramp : adc_data sampled at n).
  - Latency is 1 cycle. mem_wen is a single-cycle pulse per accepted sample.
  - self_test_mode is sampled per sample.
- After an accepted sample: waddr increments; ramp increments modulo 2**DATA_W.
- End of buffer: when the sample written to address 2**ADDR_W-1 is accepted, the state is DONE on the following edge.
  - capture_done=1 and capture_busy=0 from the same cycle the final mem_wen is high.
  - Further adc_valid is not written.
  - waddr does not wrap into a second pass.
- Simultaneous events:
  - rst has priority over everything.
  - capture_start and capture_again in the same cycle in DONE count as one request.
  - rd_busy rising during CAPTURE has no effect.

Optional Feature:
ADC_CAP_PARITY_EN
- Defined: mem_wdata is DATA_W+1 bits. Bit DATA_W is the even parity (XOR) of bits DATA_W-1:0, computed on the selected data in the same registered stage. Latency is unchanged.
- Undefined: mem_wdata is DATA_W bits and no parity logic is present.

Test Plan:
- Bench configuration for all scenarios: ADDR_W=4, DATA_W=16.
- Basic capture: capture_start, adc_valid=1 continuous, adc_data=0x100+n, decim=0 -> 16 mem_wen pulses, addr 0..15, data 0x100..0x10F. capture_done=1 in the cycle after the 16th accepted sample; no 17th write.
- Decimation: decim=2, adc_valid every cycle -> writes samples 0,3,6,...,45 to addr 0..15. Changing decim mid-capture has no effect.
- Self-test: self_test_mode=1, capture_start -> data 0x0000..0x000F. After capture_again, the ramp restarts at 0x0000.
- Hold-off: capture_again in DONE with rd_busy=1 for 20 cycles -> pend_again=1, no mem_wen for 20 cycles. CAPTURE starts on the first rd_busy=0 cycle and writes from addr 0.
- Reset and ignore rules: rst asserted after 7 writes -> next cycle all outputs 0, state IDLE. A subsequent capture_again is ignored; capture_start restarts at addr 0.
- Parity (macro defined): data 0x0001 -> bit16=1; data 0x0003 -> bit16=0.
